pwm_level_decoder: RTL and testbench

//  Receive end of the activity-LED PWM link: recovers the 8-bit brightness level from a
//  PWM line (drive = pwm_counter < level, free-running period 2**LEVEL_BITS clocks, unknown

---
 rtl/pwm_level_decoder_pkg.sv | 9 +
 rtl/pwm_level_decoder_input_sync.sv | 25 ++
 rtl/pwm_level_decoder.sv | 80 ++++++++
 tb/tb_pwm_level_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pwm_level_decoder_pkg.sv
// rtl/pwm_level_decoder_pkg.sv - shared cluster LED PWM defaults for the level decoder
package pwm_level_decoder_pkg;

  // Shared with the LED PWM transmitter so both ends agree on the period.
  localparam int LED_LEVEL_BITS      = 8;
  localparam int DEFAULT_RISE_THRESH = 64;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/pwm_level_decoder_input_sync.sv
// rtl/pwm_level_decoder_input_sync.sv - flop-chain synchroniser for the asynchronous PWM line
module pwm_level_decoder_input_sync
  import pwm_level_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_level_decoder.sv
// rtl/pwm_level_decoder.sv - recovers PWM brightness level per window and flags sudden rises
module pwm_level_decoder
  import pwm_level_decoder_pkg::*;
#(
  parameter int LEVEL_BITS  = LED_LEVEL_BITS,
  parameter int RISE_THRESH = DEFAULT_RISE_THRESH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pwm_in,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  level_valid,
  output logic                  level_full,
  output logic                  trigger_out,
  output logic                  active
);

  localparam int CW = LEVEL_BITS + 1;
  localparam logic [CW-1:0] FULL_COUNT = {1'b1, {LEVEL_BITS{1'b0}}};

  logic                  s;
  logic [LEVEL_BITS-1:0] win_cnt;
  logic [CW-1:0]         high_cnt;
  logic [LEVEL_BITS-1:0] prev_level;
  logic                  first_win;
  logic                  win_end;
  logic [CW-1:0]         sum;
  logic [LEVEL_BITS-1:0] new_level;
  logic                  rise;

  pwm_level_decoder_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_input_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pwm_in),
    .q    (s)
  );

  // The final sample of a window is folded in here so the window closes in one cycle.
  always_comb begin
    win_end   = &win_cnt;
    sum       = high_cnt + CW'(s);
    new_level = sum[LEVEL_BITS] ? {LEVEL_BITS{1'b1}} : sum[LEVEL_BITS-1:0];
    rise      = {1'b0, new_level} >= ({1'b0, prev_level} + CW'(RISE_THRESH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt     <= '0;
      high_cnt    <= '0;
      prev_level  <= '0;
      first_win   <= 1'b1;
      level       <= '0;
      level_valid <= 1'b0;
      level_full  <= 1'b0;
      trigger_out <= 1'b0;
      active      <= 1'b0;
    end else begin
      win_cnt     <= win_cnt + LEVEL_BITS'(1);
      level_valid <= 1'b0;
      trigger_out <= 1'b0;
      if (win_end) begin
        level       <= new_level;
        level_full  <= (sum == FULL_COUNT);
        active      <= (sum != '0);
        high_cnt    <= '0;
        prev_level  <= new_level;
        // The first window is contaminated by the cleared synchroniser.
        level_valid <= !first_win;
        trigger_out <= !first_win && rise;
        first_win   <= 1'b0;
      end else begin
        high_cnt <= sum;
      end
    end
  end

endmodule

// File: tb/tb_pwm_level_decoder.sv
// tb/tb_pwm_level_decoder.sv - randomized bench for pwm_level_decoder against a window-count model
module tb_pwm_level_decoder;
  import pwm_level_decoder_pkg::*;

  localparam int WIN = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] level;
  logic       level_valid;
  logic       level_full;
  logic       trigger_out;
  logic       active;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: edges since reset release and the pwm value sampled at each of them.
  int n = 0;
  bit hist[$];
  int exp_level = 0;
  bit rst_s;
  bit async_chk = 1'b0;

  // Transmitter model
  int tx_cnt = 0;
  int cur_lvl = 0;

  pwm_level_decoder #(
    .LEVEL_BITS (LED_LEVEL_BITS),
    .RISE_THRESH(DEFAULT_RISE_THRESH),
    .SYNC_STAGES(DEFAULT_SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .level      (level),
    .level_valid(level_valid),
    .level_full (level_full),
    .trigger_out(trigger_out),
    .active     (active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  // Window k counts the pwm samples taken at edges (k-1)*WIN-1 .. k*WIN-2 after reset
  // release; edges at or before release contribute nothing because the synchroniser was cleared.
  function automatic int win_sum(input int k);
    int s = 0;
    for (int i = (k - 1) * WIN - 1; i <= k * WIN - 2; i++)
      if (i >= 1) s += int'(hist[i-1]);
    return s;
  endfunction

  function automatic int sat(input int v);
    return (v > WIN - 1) ? WIN - 1 : v;
  endfunction

  always @(posedge clk) begin
    int k, sm, lv, prv;
    rst_s = reset;
    if (rst_s) begin
      n = 0;
      hist.delete();
    end else begin
      n++;
      hist.push_back(pwm_in);
    end
    #1;
    if (rst_s) begin
      exp_level = 0;
      check_eq("rst_outputs", {level, level_valid, level_full, trigger_out, active}, 32'd0);
    end else if (n % WIN == 0) begin
      k   = n / WIN;
      sm  = win_sum(k);
      lv  = sat(sm);
      prv = (k >= 2) ? sat(win_sum(k - 1)) : 0;
      exp_level = lv;
      check_eq("win_valid", level_valid, (k >= 2) ? 1 : 0);
      check_eq("win_level", level, lv);
      check_eq("win_full", level_full, (sm == WIN) ? 1 : 0);
      check_eq("win_active", active, (sm != 0) ? 1 : 0);
      check_eq("win_trigger", trigger_out, (k >= 2 && lv >= prv + DEFAULT_RISE_THRESH) ? 1 : 0);
      check_eq("win_no_x", $isunknown({level, level_valid, level_full, trigger_out, active}), 0);
      if (async_chk)
        check_eq("async_range", (level >= 8'd126 && level <= 8'd130) ? 1 : 0, 1);
    end else begin
      check_eq("idle_valid", level_valid, 0);
      check_eq("idle_trigger", trigger_out, 0);
      check_eq("hold_level", level, exp_level);
    end
  end

  // Called at a negedge: sets the value sampled at the next posedge.
  task automatic drive_one();
    pwm_in = (tx_cnt < cur_lvl);
    tx_cnt = (tx_cnt + 1) % WIN;
    @(negedge clk);
  endtask

  // Aligned changes make the first sample of the new level open a decoder window.
  task automatic run_level(input int lvl, input int windows, input bit aligned);
    if (aligned)
      while (((n + 1) % WIN) != WIN - 1) drive_one();
    cur_lvl = lvl;
    repeat (windows * WIN) drive_one();
  endtask

  task automatic async_toggle(input int toggles);
    int jp, jn;
    @(posedge clk);
    jp = $urandom_range(0, 8) - 4;
    #(5 + jp);
    repeat (toggles) begin
      pwm_in = ~pwm_in;
      jn = $urandom_range(0, 8) - 4;
      #(40 + jn - jp);
      jp = jn;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_cnt = $urandom_range(0, WIN - 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_level(100, 8, 1'b0);
    run_level(0, 3, 1'b0);
    run_level(WIN, 3, 1'b0);

    run_level(0, 2, 1'b1);
    run_level(255, 1, 1'b1);
    for (int l = 230; l >= 0; l -= 25) run_level(l, 1, 1'b1);

    run_level(100, 2, 1'b1);
    run_level(163, 2, 1'b1);
    run_level(100, 2, 1'b1);
    run_level(164, 2, 1'b1);

    repeat (4) run_level($urandom_range(0, WIN), $urandom_range(1, 2), $urandom_range(0, 1));

    cur_lvl = 200;
    while ((n % WIN) != 77) drive_one();
    reset = 1'b1;
    repeat (3) drive_one();
    reset = 1'b0;
    run_level(200, 3, 1'b0);

    fork
      async_toggle(256);
      begin
        repeat (300) @(negedge clk);
        async_chk = 1'b1;
        repeat (512) @(negedge clk);
        async_chk = 1'b0;
      end
    join
    repeat (WIN) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
